// File: rtl/cpu_pkg.sv
// Shared types for the hardwired control unit: T-state enum, opcode values,
// instruction classes and the packed strobe bundle driven onto the datapath.
package cpu_pkg;

    typedef enum logic [3:0] {
        T0, T1, T1W, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BRZR = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_ALU3, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_MFHI, CLS_MFLO,
        CLS_LDI, CLS_LD, CLS_ST, CLS_IN, CLS_OUT, CLS_HALT, CLS_BRZR, CLS_JR
    } instr_class_t;

    // Field order matches the port concatenation in control_sequencer.
    typedef struct packed {
        logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
        logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, con_in, outport_in;
        logic gra, grb, grc, r_in, r_out, ba_out, inc_pc;
        logic mem_read, mem_write, mem_enable;
    } strobes_t;

    function automatic instr_class_t classify(input logic [4:0] op);
        instr_class_t cls;
        cls = CLS_NOP;
        if (op >= OP_ADD && op <= OP_SHL) begin
            cls = CLS_ALU3;
        end else begin
            case (op)
                OP_LD:                     cls = CLS_LD;
                OP_LDI:                    cls = CLS_LDI;
                OP_ST:                     cls = CLS_ST;
                OP_ADDI, OP_ANDI, OP_ORI:  cls = CLS_IMM;
                OP_DIV, OP_MUL:            cls = CLS_MULDIV;
                OP_NEG, OP_NOT:            cls = CLS_UNARY;
                OP_BRZR:                   cls = CLS_BRZR;
                OP_JR:                     cls = CLS_JR;
                OP_IN:                     cls = CLS_IN;
                OP_OUT:                    cls = CLS_OUT;
                OP_MFHI:                   cls = CLS_MFHI;
                OP_MFLO:                   cls = CLS_MFLO;
                OP_HALT:                   cls = CLS_HALT;
                default:                   cls = CLS_NOP;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory state has waited for memory_done; flags a timeout on
// the (WAIT_MAX-1)th cycle of one access that still has no memory_done.
module mem_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic done,
    output logic timeout
);

    localparam int W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [W-1:0] LAST = W'(WAIT_MAX - 2);

    logic [W-1:0] count;

    // Leaving the memory states (or completing) rearms the counter for the next access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active || done) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + W'(1);
        end
    end

    assign timeout = active && !done && (count == LAST);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0..T2, execute T3..T7 per instruction class.
// Optional macro CTRL_BRANCH_EN enables brzr/jr; otherwise they execute as nop.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int WAIT_MAX = 16
) (
    input  logic       Clock,
    input  logic       clear,
    input  logic [4:0] ir_opcode,
    input  logic       con_ff_bit,
    input  logic       memory_done,
    output logic       HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
    output logic       MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
    output logic       Gra, Grb, Grc, Rin, Rout, BAout, IncPC,
    output logic       Mem_Read, Mem_Write, Mem_enable512x32,
    output logic [4:0] opcode,
    output logic       run,
    output logic       mem_fault
);

    state_t       state, state_next;
    instr_class_t cls;
    strobes_t     strb;
    logic [4:0]   op_int;
    logic         mem_active, timeout;

`ifdef CTRL_BRANCH_EN
    assign cls = classify(ir_opcode);
`else
    assign cls = (classify(ir_opcode) inside {CLS_BRZR, CLS_JR}) ? CLS_NOP : classify(ir_opcode);
`endif

    assign mem_active = (state == T1) || (state == T1W) ||
                        (state == T6 && cls == CLS_LD) || (state == T7 && cls == CLS_ST);

    mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
        .clk    (Clock),
        .rst_n  (clear),
        .active (mem_active),
        .done   (memory_done),
        .timeout(timeout)
    );

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state     <= T0;
            mem_fault <= 1'b0;
        end else begin
            state <= state_next;
            if (timeout) mem_fault <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        strb       = '0;
        op_int     = '0;
        if (state inside {T3, T4, T5, T6, T7}) op_int = ir_opcode;
        case (state)
            T0: begin
                strb.pc_out = 1'b1; strb.mar_in = 1'b1; strb.inc_pc = 1'b1; strb.z_in = 1'b1;
                state_next = T1;
            end
            T1, T1W: begin
                strb.mem_read = 1'b1; strb.mem_enable = 1'b1; strb.mdr_in = 1'b1;
                if (state == T1) begin
                    strb.zlo_out = 1'b1; strb.pc_in = 1'b1;
                end
                if (memory_done)  state_next = T2;
                else if (timeout) state_next = HALT;
                else              state_next = T1W;
            end
            T2: begin
                strb.mdr_out = 1'b1; strb.ir_in = 1'b1;
                state_next = T3;
            end
            T3: begin
                state_next = T0;
                case (cls)
                    CLS_ALU3, CLS_IMM: begin
                        strb.grb = 1'b1; strb.r_out = 1'b1; strb.y_in = 1'b1; state_next = T4;
                    end
                    CLS_UNARY: begin
                        strb.grb = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1; state_next = T4;
                    end
                    CLS_MULDIV: begin
                        strb.gra = 1'b1; strb.r_out = 1'b1; strb.y_in = 1'b1; state_next = T4;
                    end
                    CLS_MFHI: begin strb.gra = 1'b1; strb.r_in = 1'b1; strb.hi_out = 1'b1; end
                    CLS_MFLO: begin strb.gra = 1'b1; strb.r_in = 1'b1; strb.lo_out = 1'b1; end
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        strb.grb = 1'b1; strb.ba_out = 1'b1; strb.y_in = 1'b1; state_next = T4;
                    end
                    CLS_IN:  begin strb.inport_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
                    CLS_OUT: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.outport_in = 1'b1; end
                    CLS_BRZR: begin
                        strb.gra = 1'b1; strb.r_out = 1'b1; strb.con_in = 1'b1; state_next = T4;
                    end
                    CLS_JR:   begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_in = 1'b1; end
                    CLS_HALT: state_next = HALT;
                    default: ;
                endcase
            end
            T4: begin
                state_next = T0;
                case (cls)
                    CLS_ALU3: begin
                        strb.grc = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1; state_next = T5;
                    end
                    CLS_IMM: begin strb.c_out = 1'b1; strb.z_in = 1'b1; state_next = T5; end
                    CLS_UNARY: begin strb.zlo_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
                    CLS_MULDIV: begin
                        strb.grb = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1; state_next = T5;
                    end
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        strb.c_out = 1'b1; strb.z_in = 1'b1; op_int = OP_ADD; state_next = T5;
                    end
                    CLS_BRZR: begin strb.pc_out = 1'b1; strb.y_in = 1'b1; state_next = T5; end
                    default: ;
                endcase
            end
            T5: begin
                state_next = T0;
                case (cls)
                    CLS_ALU3, CLS_IMM, CLS_LDI: begin
                        strb.zlo_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1;
                    end
                    CLS_MULDIV: begin strb.zlo_out = 1'b1; strb.lo_in = 1'b1; state_next = T6; end
                    CLS_LD, CLS_ST: begin strb.zlo_out = 1'b1; strb.mar_in = 1'b1; state_next = T6; end
                    CLS_BRZR: begin
                        strb.c_out = 1'b1; strb.z_in = 1'b1; op_int = OP_ADD; state_next = T6;
                    end
                    default: ;
                endcase
            end
            T6: begin
                state_next = T0;
                case (cls)
                    CLS_MULDIV: begin strb.zhi_out = 1'b1; strb.hi_in = 1'b1; end
                    CLS_LD: begin
                        strb.mem_read = 1'b1; strb.mem_enable = 1'b1; strb.mdr_in = 1'b1;
                        if (memory_done)  state_next = T7;
                        else if (timeout) state_next = HALT;
                        else              state_next = T6;
                    end
                    CLS_ST: begin
                        strb.gra = 1'b1; strb.r_out = 1'b1; strb.mdr_in = 1'b1; state_next = T7;
                    end
                    // The only output that looks at an input other than ir_opcode.
                    CLS_BRZR: begin
                        strb.zlo_out = con_ff_bit; strb.pc_in = con_ff_bit;
                    end
                    default: ;
                endcase
            end
            T7: begin
                state_next = T0;
                case (cls)
                    CLS_LD: begin strb.mdr_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
                    CLS_ST: begin
                        strb.mem_write = 1'b1; strb.mem_enable = 1'b1;
                        if (memory_done)  state_next = T0;
                        else if (timeout) state_next = HALT;
                        else              state_next = T7;
                    end
                    default: ;
                endcase
            end
            HALT:    state_next = HALT;
            default: state_next = T0;
        endcase
    end

    // clear forces every strobe low immediately, not just at the next edge.
    assign {HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
            MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
            Gra, Grb, Grc, Rin, Rout, BAout, IncPC,
            Mem_Read, Mem_Write, Mem_enable512x32} = clear ? strb : '0;
    assign opcode = clear ? op_int : 5'd0;
    assign run    = (state != HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed vector table, hand-written
// corner sequences and a randomized instruction stream against a per-class step model.
module tb_control_sequencer;

    localparam int WAIT_MAX = 16;

    localparam logic [27:0] HI_OUT  = 28'd1 << 27, LO_OUT  = 28'd1 << 26, ZHI_OUT = 28'd1 << 25;
    localparam logic [27:0] ZLO_OUT = 28'd1 << 24, PC_OUT  = 28'd1 << 23, MDR_OUT = 28'd1 << 22;
    localparam logic [27:0] INP_OUT = 28'd1 << 21, C_OUT   = 28'd1 << 20, MAR_IN  = 28'd1 << 19;
    localparam logic [27:0] Z_IN    = 28'd1 << 18, PC_IN   = 28'd1 << 17, MDR_IN  = 28'd1 << 16;
    localparam logic [27:0] IR_IN   = 28'd1 << 15, Y_IN    = 28'd1 << 14, HI_IN   = 28'd1 << 13;
    localparam logic [27:0] LO_IN   = 28'd1 << 12, CON_IN  = 28'd1 << 11, OUTP_IN = 28'd1 << 10;
    localparam logic [27:0] GRA     = 28'd1 << 9,  GRB     = 28'd1 << 8,  GRC     = 28'd1 << 7;
    localparam logic [27:0] R_IN    = 28'd1 << 6,  R_OUT   = 28'd1 << 5,  BA_OUT  = 28'd1 << 4;
    localparam logic [27:0] INC_PC  = 28'd1 << 3,  MEM_RD  = 28'd1 << 2,  MEM_WR  = 28'd1 << 1;
    localparam logic [27:0] MEM_EN  = 28'd1 << 0;
    localparam logic [27:0] FETCH0  = PC_OUT | MAR_IN | INC_PC | Z_IN;
    localparam logic [27:0] FETCH1  = ZLO_OUT | PC_IN | MEM_RD | MEM_EN | MDR_IN;
    localparam logic [27:0] RD_WAIT = MEM_RD | MEM_EN | MDR_IN;
    localparam logic [27:0] FETCH2  = MDR_OUT | IR_IN;
    localparam logic [4:0]  ADD_OP  = 5'd3;

    logic       Clock, clear, con_ff_bit, memory_done;
    logic [4:0] ir_opcode, opcode;
    logic       HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
    logic       MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in;
    logic       Gra, Grb, Grc, Rin, Rout, BAout, IncPC;
    logic       Mem_Read, Mem_Write, Mem_enable512x32, run, mem_fault;
    logic [27:0] strobes_act;

    control_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .Clock(Clock), .clear(clear), .ir_opcode(ir_opcode), .con_ff_bit(con_ff_bit),
        .memory_done(memory_done),
        .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout),
        .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .CONin(CONin), .outport_in(outport_in),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .IncPC(IncPC),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32),
        .opcode(opcode), .run(run), .mem_fault(mem_fault)
    );

    assign strobes_act = {HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
                          MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
                          Gra, Grb, Grc, Rin, Rout, BAout, IncPC,
                          Mem_Read, Mem_Write, Mem_enable512x32};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic        clr;
        logic [4:0]  ir;
        logic        done;
        logic        con;
        logic [27:0] strobes;
        logic [4:0]  op;
        logic        run;
        logic        fault;
    } vec_t;

    vec_t sched[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [4:0] rnd5();
        return 5'($urandom);
    endfunction

    function automatic void push(input logic clr, input logic [4:0] ir, input logic done,
                                 input logic con, input logic [27:0] strobes, input logic [4:0] op,
                                 input logic run_e, input logic fault_e);
        vec_t v;
        v.clr = clr; v.ir = ir; v.done = done; v.con = con;
        v.strobes = strobes; v.op = op; v.run = run_e; v.fault = fault_e;
        sched.push_back(v);
    endfunction

    function automatic void push_clear();
        push(1'b0, rnd5(), rb(), rb(), 28'd0, 5'd0, 1'b1, 1'b0);
    endfunction

    function automatic void push_fetch();
        push(1'b1, rnd5(), rb(), rb(), FETCH0, 5'd0, 1'b1, 1'b0);
        push(1'b1, rnd5(), 1'b1, rb(), FETCH1, 5'd0, 1'b1, 1'b0);
        push(1'b1, rnd5(), rb(), rb(), FETCH2, 5'd0, 1'b1, 1'b0);
    endfunction

    function automatic void push_halted(input int n, input logic fault_e);
        for (int i = 0; i < n; i++) push(1'b1, rnd5(), rb(), rb(), 28'd0, 5'd0, 1'b0, fault_e);
    endfunction

    task automatic applyStimulus(input vec_t v);
        clear       = v.clr;
        ir_opcode   = v.ir;
        memory_done = v.done;
        con_ff_bit  = v.con;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        checks++;
        if ({strobes_act, opcode, run, mem_fault} !== {v.strobes, v.op, v.run, v.fault}) begin
            failures++;
            $display("[TB] FAIL %s: got strobes=%h opcode=%b run=%b fault=%b, want strobes=%h opcode=%b run=%b fault=%b",
                     name, strobes_act, opcode, run, mem_fault, v.strobes, v.op, v.run, v.fault);
        end
    endtask

    task automatic run_sched(input string tag);
        for (int i = 0; i < sched.size(); i++) begin
            @(posedge Clock);
            #1;
            applyStimulus(sched[i]);
            @(negedge Clock);
            checkOutput(sched[i], $sformatf("%s[%0d]", tag, i));
        end
        sched.delete();
    endtask

    // One memory access: done arrives on cycle lat (0-based); the access may last at most WAIT_MAX-1 cycles.
    task automatic mem_access(input bit fetch, input logic [4:0] op, input logic [27:0] first,
                              input logic [27:0] rest, input logic [4:0] opx, input int lat,
                              output bit ok);
        ok = 1'b0;
        for (int c = 0; c < WAIT_MAX - 1; c++) begin
            push(1'b1, fetch ? rnd5() : op, (c == lat), rb(), (c == 0) ? first : rest, opx, 1'b1, 1'b0);
            if (c == lat) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic model_instr(input logic [4:0] op, input int flat, input int mlat,
                               output bit halted, output bit faulted);
        logic [27:0] steps[$];
        int          mem_idx, add_idx, brz_idx;
        bit          ok;
        logic        c;
        halted = 1'b0; faulted = 1'b0;
        mem_idx = -1; add_idx = -1; brz_idx = -1;
        push(1'b1, rnd5(), rb(), rb(), FETCH0, 5'd0, 1'b1, 1'b0);
        mem_access(1'b1, op, FETCH1, RD_WAIT, 5'd0, flat, ok);
        if (!ok) begin
            halted = 1'b1; faulted = 1'b1;
            return;
        end
        push(1'b1, rnd5(), rb(), rb(), FETCH2, 5'd0, 1'b1, 1'b0);
        if (op >= 5'd3 && op <= 5'd11) begin
            steps = '{GRB | R_OUT | Y_IN, GRC | R_OUT | Z_IN, ZLO_OUT | GRA | R_IN};
        end else begin
            case (op)
                5'd0: begin
                    steps = '{GRB | BA_OUT | Y_IN, C_OUT | Z_IN, ZLO_OUT | MAR_IN, RD_WAIT, MDR_OUT | GRA | R_IN};
                    mem_idx = 3; add_idx = 1;
                end
                5'd1: begin
                    steps = '{GRB | BA_OUT | Y_IN, C_OUT | Z_IN, ZLO_OUT | GRA | R_IN};
                    add_idx = 1;
                end
                5'd2: begin
                    steps = '{GRB | BA_OUT | Y_IN, C_OUT | Z_IN, ZLO_OUT | MAR_IN, GRA | R_OUT | MDR_IN, MEM_WR | MEM_EN};
                    mem_idx = 4; add_idx = 1;
                end
                5'd12, 5'd13, 5'd14: steps = '{GRB | R_OUT | Y_IN, C_OUT | Z_IN, ZLO_OUT | GRA | R_IN};
                5'd15, 5'd16: steps = '{GRA | R_OUT | Y_IN, GRB | R_OUT | Z_IN, ZLO_OUT | LO_IN, ZHI_OUT | HI_IN};
                5'd17, 5'd18: steps = '{GRB | R_OUT | Z_IN, ZLO_OUT | GRA | R_IN};
                5'd22: steps = '{INP_OUT | GRA | R_IN};
                5'd23: steps = '{GRA | R_OUT | OUTP_IN};
                5'd24: steps = '{GRA | R_IN | HI_OUT};
                5'd25: steps = '{GRA | R_IN | LO_OUT};
`ifdef CTRL_BRANCH_EN
                5'd19: begin
                    steps = '{GRA | R_OUT | CON_IN, PC_OUT | Y_IN, C_OUT | Z_IN, 28'd0};
                    add_idx = 2; brz_idx = 3;
                end
                5'd20: steps = '{GRA | R_OUT | PC_IN};
`endif
                default: steps = '{28'd0};
            endcase
        end
        for (int i = 0; i < steps.size(); i++) begin
            logic [4:0] o;
            o = (i == add_idx) ? ADD_OP : op;
            if (i == mem_idx) begin
                mem_access(1'b0, op, steps[i], steps[i], o, mlat, ok);
                if (!ok) begin
                    halted = 1'b1; faulted = 1'b1;
                    return;
                end
            end else if (i == brz_idx) begin
                c = rb();
                push(1'b1, op, rb(), c, c ? (ZLO_OUT | PC_IN) : 28'd0, o, 1'b1, 1'b0);
            end else begin
                push(1'b1, op, rb(), rb(), steps[i], o, 1'b1, 1'b0);
            end
        end
        halted = (op == 5'd27);
    endtask

    function automatic int pick_lat(input bit allow_fault);
        int r;
        r = $urandom_range(0, 11);
        if (r < 7)                   return $urandom_range(0, 3);
        if (r < 9)                   return WAIT_MAX - 2;
        if (r == 9 && allow_fault)   return WAIT_MAX - 1;
        return 0;
    endfunction

    initial begin
        bit         halted, faulted;
        logic [4:0] op;
        clear = 1'b0; ir_opcode = 5'd0; con_ff_bit = 1'b0; memory_done = 1'b0;

        // Directed table: mfhi with immediate fetch, mflo with slow fetch, add.
        push(1'b0, 5'd0,     1'b0, 1'b0, 28'd0,                  5'd0,     1'b1, 1'b0);
        push(1'b1, 5'd9,     1'b0, 1'b0, FETCH0,                 5'd0,     1'b1, 1'b0);
        push(1'b1, 5'd4,     1'b1, 1'b0, FETCH1,                 5'd0,     1'b1, 1'b0);
        push(1'b1, 5'd31,    1'b0, 1'b1, FETCH2,                 5'd0,     1'b1, 1'b0);
        push(1'b1, 5'b11000, 1'b1, 1'b0, GRA | HI_OUT | R_IN,    5'b11000, 1'b1, 1'b0);
        push(1'b1, 5'd2,     1'b0, 1'b0, FETCH0,                 5'd0,     1'b1, 1'b0);
        push(1'b1, 5'd2,     1'b0, 1'b0, FETCH1,                 5'd0,     1'b1, 1'b0);
        push(1'b1, 5'd0,     1'b0, 1'b1, RD_WAIT,                5'd0,     1'b1, 1'b0);
        push(1'b1, 5'd0,     1'b0, 1'b0, RD_WAIT,                5'd0,     1'b1, 1'b0);
        push(1'b1, 5'd0,     1'b1, 1'b0, RD_WAIT,                5'd0,     1'b1, 1'b0);
        push(1'b1, 5'd0,     1'b0, 1'b0, FETCH2,                 5'd0,     1'b1, 1'b0);
        push(1'b1, 5'b11001, 1'b1, 1'b1, GRA | LO_OUT | R_IN,    5'b11001, 1'b1, 1'b0);
        push(1'b1, 5'd27,    1'b1, 1'b0, FETCH0,                 5'd0,     1'b1, 1'b0);
        push(1'b1, 5'd27,    1'b1, 1'b0, FETCH1,                 5'd0,     1'b1, 1'b0);
        push(1'b1, 5'd27,    1'b0, 1'b0, FETCH2,                 5'd0,     1'b1, 1'b0);
        push(1'b1, 5'b00011, 1'b1, 1'b0, GRB | R_OUT | Y_IN,     5'b00011, 1'b1, 1'b0);
        push(1'b1, 5'b00011, 1'b0, 1'b1, GRC | R_OUT | Z_IN,     5'b00011, 1'b1, 1'b0);
        push(1'b1, 5'b00011, 1'b1, 1'b0, ZLO_OUT | GRA | R_IN,   5'b00011, 1'b1, 1'b0);
        push(1'b1, 5'b00011, 1'b0, 1'b0, FETCH0,                 5'd0,     1'b1, 1'b0);
        run_sched("table");

        // st whose memory never answers: timeout, HALT, then recovery by clear.
        push_clear();
        push_fetch();
        push(1'b1, 5'd2, 1'b1, rb(), GRB | BA_OUT | Y_IN,   5'd2,   1'b1, 1'b0);
        push(1'b1, 5'd2, 1'b1, rb(), C_OUT | Z_IN,         ADD_OP, 1'b1, 1'b0);
        push(1'b1, 5'd2, 1'b1, rb(), ZLO_OUT | MAR_IN,     5'd2,   1'b1, 1'b0);
        push(1'b1, 5'd2, 1'b1, rb(), GRA | R_OUT | MDR_IN, 5'd2,   1'b1, 1'b0);
        for (int i = 0; i < WAIT_MAX - 1; i++)
            push(1'b1, 5'd2, 1'b0, rb(), MEM_WR | MEM_EN, 5'd2, 1'b1, 1'b0);
        push_halted(3, 1'b1);
        push_clear();
        push(1'b1, rnd5(), rb(), rb(), FETCH0, 5'd0, 1'b1, 1'b0);
        run_sched("st_timeout");

        // clear asserted while ld waits in T6.
        push_clear();
        push_fetch();
        push(1'b1, 5'd0, 1'b0, rb(), GRB | BA_OUT | Y_IN, 5'd0,   1'b1, 1'b0);
        push(1'b1, 5'd0, 1'b1, rb(), C_OUT | Z_IN,       ADD_OP, 1'b1, 1'b0);
        push(1'b1, 5'd0, 1'b0, rb(), ZLO_OUT | MAR_IN,   5'd0,   1'b1, 1'b0);
        push(1'b1, 5'd0, 1'b0, rb(), RD_WAIT,            5'd0,   1'b1, 1'b0);
        push(1'b1, 5'd0, 1'b0, rb(), RD_WAIT,            5'd0,   1'b1, 1'b0);
        push(1'b0, 5'd0, 1'b0, rb(), 28'd0,              5'd0,   1'b1, 1'b0);
        push(1'b1, 5'd0, 1'b1, rb(), FETCH0,             5'd0,   1'b1, 1'b0);
        push(1'b1, 5'd0, 1'b1, rb(), FETCH1,             5'd0,   1'b1, 1'b0);
        run_sched("ld_clear");

        // brzr with both CON values, then jr.
        push_clear();
        for (int k = 0; k < 2; k++) begin
            push_fetch();
`ifdef CTRL_BRANCH_EN
            push(1'b1, 5'd19, rb(), rb(), GRA | R_OUT | CON_IN, 5'd19,  1'b1, 1'b0);
            push(1'b1, 5'd19, rb(), rb(), PC_OUT | Y_IN,        5'd19,  1'b1, 1'b0);
            push(1'b1, 5'd19, rb(), rb(), C_OUT | Z_IN,         ADD_OP, 1'b1, 1'b0);
            push(1'b1, 5'd19, rb(), 1'(k), (k == 1) ? (ZLO_OUT | PC_IN) : 28'd0, 5'd19, 1'b1, 1'b0);
`else
            push(1'b1, 5'd19, rb(), 1'(k), 28'd0, 5'd19, 1'b1, 1'b0);
`endif
        end
        push_fetch();
`ifdef CTRL_BRANCH_EN
        push(1'b1, 5'd20, rb(), rb(), GRA | R_OUT | PC_IN, 5'd20, 1'b1, 1'b0);
`else
        push(1'b1, 5'd20, rb(), rb(), 28'd0, 5'd20, 1'b1, 1'b0);
`endif
        push(1'b1, rnd5(), rb(), rb(), FETCH0, 5'd0, 1'b1, 1'b0);
        run_sched("branch");

        // Boundary: done on the last permitted cycle of fetch and of st.
        push_clear();
        model_instr(5'd2, WAIT_MAX - 2, WAIT_MAX - 2, halted, faulted);
        push(1'b1, rnd5(), rb(), rb(), FETCH0, 5'd0, 1'b1, 1'b0);
        run_sched("late_done");

        // Randomized instruction stream.
        push_clear();
        for (int n = 0; n < 80; n++) begin
            op = rnd5();
            if (op == 5'd27 && $urandom_range(0, 2) != 0) op = 5'd26;
            model_instr(op, pick_lat($urandom_range(0, 3) == 0), pick_lat(1'b1), halted, faulted);
            if (halted) begin
                push_halted(3, faulted);
                push_clear();
            end
        end
        run_sched("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
